// File: rtl/bmw_op_sched_pkg.sv
// bmw_op_sched_pkg: shared types, heap geometry and defaults for the BMW op sequencer.
package bmw_op_sched_pkg;
    localparam int ORDER = 4;
    localparam int LEVEL = 8;
    localparam int PTW_D = 16;
    localparam int MTW_D = 17;

    typedef struct packed {
        logic [MTW_D-1:0] meta;
        logic [PTW_D-1:0] prio;
    } entry_t;

    typedef enum logic [1:0] {OP_NONE, OP_PUSH, OP_POP} op_e;
    typedef enum logic {SLOT_OPEN, GAP} state_e;

    // Entries held by a full ORDER-ary heap with the given number of levels.
    function automatic int nb_elements(input int levels);
        int n;
        int w;
        n = 0;
        w = 1;
        for (int l = 0; l < levels; l++) begin
            w = w * ORDER;
            n = n + w;
        end
        return n;
    endfunction

    localparam int CAPACITY_D = nb_elements(LEVEL);
endpackage

// File: rtl/bmw_op_sched_if.sv
// bmw_op_sched_if: requester, response and BMW-core signals of the op sequencer.
interface bmw_op_sched_if #(
    parameter int NPUSH = 4,
    parameter int EW    = 33,
    parameter int CNTW  = 17
);
    logic [NPUSH-1:0]    push_valid;
    logic [NPUSH*EW-1:0] push_data;
    logic [NPUSH-1:0]    push_ready;
    logic                pop_valid;
    logic                pop_ready;
    logic                pop_resp_valid;
    logic [EW-1:0]       pop_resp_data;
    logic                bmw_push;
    logic [EW-1:0]       bmw_push_data;
    logic                bmw_pop;
    logic [EW-1:0]       bmw_pop_data;
    logic [CNTW-1:0]     occupancy;
    logic                empty;
    logic                full;

    modport master (
        output push_valid, push_data, pop_valid, bmw_pop_data,
        input  push_ready, pop_ready, pop_resp_valid, pop_resp_data,
        input  bmw_push, bmw_push_data, bmw_pop, occupancy, empty, full
    );

    modport slave (
        input  push_valid, push_data, pop_valid, bmw_pop_data,
        output push_ready, pop_ready, pop_resp_valid, pop_resp_data,
        output bmw_push, bmw_push_data, bmw_pop, occupancy, empty, full
    );
endinterface

// File: rtl/bmw_op_sched_rr_arbiter.sv
// bmw_op_sched_rr_arbiter: one-hot round-robin grant; search starts after the last granted port.
module bmw_op_sched_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         user_clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);
    localparam int IW = N > 1 ? $clog2(N) : 1;

    logic [IW-1:0] ptr;
    logic [IW-1:0] k;
    logic [IW-1:0] sel;
    logic          found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        k     = '0;
        sel   = '0;
        for (int i = 0; i < N; i++) begin
            k = IW'((int'(ptr) + i) % N);
            if (!found && req[k]) begin
                gnt[k] = 1'b1;
                sel    = k;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge user_clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (advance && found)
            ptr <= (sel == IW'(N-1)) ? '0 : sel + 1'b1;
    end
endmodule

// File: rtl/bmw_op_sched.sv
// bmw_op_sched: merges push ports and a pop requester into the BMW op slot, gating on
// occupancy and spacing issues by ISSUE_GAP; returns pop results in issue order.
module bmw_op_sched
    import bmw_op_sched_pkg::*;
#(
    parameter int NPUSH     = 4,
    parameter int PTW       = PTW_D,
    parameter int MTW       = MTW_D,
    parameter int CAPACITY  = CAPACITY_D,
    parameter int ISSUE_GAP = 2,
    parameter int POP_LAT   = 1
) (
    input logic          user_clk,
    input logic          rst_n,
    bmw_op_sched_if.slave bus
);
    localparam int EW   = MTW + PTW;
    localparam int CNTW = $clog2(CAPACITY + 1);
    localparam int GW   = ISSUE_GAP > 2 ? $clog2(ISSUE_GAP - 1) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(ISSUE_GAP > 1 ? ISSUE_GAP - 2 : 0);

    state_e           state;
    state_e           state_n;
    logic [GW-1:0]    gap_cnt;
    logic [NPUSH-1:0] gnt;
    logic             push_elig;
    logic             pop_elig;
    logic             push_hs;
    logic             pop_hs;
    logic [EW-1:0]    sel_data;
    op_e              last_op;
    logic [POP_LAT-1:0] tag;

    bmw_op_sched_rr_arbiter #(.N(NPUSH)) u_arb (
        .user_clk (user_clk),
        .rst_n    (rst_n),
        .req      (bus.push_valid),
        .advance  (push_hs),
        .gnt      (gnt)
    );

    always_ff @(posedge user_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SLOT_OPEN;
            gap_cnt <= '0;
        end else begin
            state   <= state_n;
            gap_cnt <= (state == SLOT_OPEN) ? GAP_LOAD : gap_cnt - 1'b1;
        end
    end

    always_comb begin
        state_n = (state == SLOT_OPEN)
                ? (((push_hs || pop_hs) && ISSUE_GAP > 1) ? GAP : SLOT_OPEN)
                : ((gap_cnt == '0) ? SLOT_OPEN : GAP);
    end

    // On contention the kind not granted last wins; OP_NONE after reset lets push go first.
    always_comb begin
        push_elig      = |bus.push_valid && !bus.full;
        pop_elig       = bus.pop_valid && !bus.empty;
        push_hs        = state == SLOT_OPEN && push_elig && (!pop_elig || last_op != OP_PUSH);
        pop_hs         = state == SLOT_OPEN && pop_elig && !push_hs;
        bus.push_ready = push_hs ? gnt : '0;
        bus.pop_ready  = pop_hs;
        sel_data       = '0;
        for (int k = 0; k < NPUSH; k++)
            sel_data = sel_data | (gnt[k] ? bus.push_data[k*EW +: EW] : '0);
    end

    always_ff @(posedge user_clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.bmw_push      <= 1'b0;
            bus.bmw_pop       <= 1'b0;
            bus.bmw_push_data <= '0;
            bus.occupancy     <= '0;
            last_op           <= OP_NONE;
        end else begin
            bus.bmw_push <= push_hs;
            bus.bmw_pop  <= pop_hs;
            if (push_hs)
                bus.bmw_push_data <= sel_data;
            bus.occupancy <= push_hs ? bus.occupancy + 1'b1
                           : pop_hs  ? bus.occupancy - 1'b1 : bus.occupancy;
            last_op <= push_hs ? OP_PUSH : pop_hs ? OP_POP : last_op;
        end
    end

    assign bus.empty = bus.occupancy == '0;
    assign bus.full  = bus.occupancy == CNTW'(CAPACITY);

    // The tag reaches the top bit in the cycle the core presents pop data.
    always_ff @(posedge user_clk or negedge rst_n) begin
        if (!rst_n) begin
            tag                <= '0;
            bus.pop_resp_valid <= 1'b0;
            bus.pop_resp_data  <= '0;
        end else begin
            tag                <= POP_LAT'({tag, bus.bmw_pop});
            bus.pop_resp_valid <= tag[POP_LAT-1];
            if (tag[POP_LAT-1])
                bus.pop_resp_data <= bus.bmw_pop_data;
        end
    end
endmodule

// File: tb/tb_bmw_op_sched.sv
// tb_bmw_op_sched: directed tables and sequences plus a randomized run against a
// cycle-timestamp reference model of the sequencer (CAPACITY=4 instance).
module tb_bmw_op_sched;
    import bmw_op_sched_pkg::*;

    localparam int EW  = MTW_D + PTW_D;
    localparam int GAP = 2;
    localparam int CAP = 4;

    typedef struct {
        logic [3:0] pv;
        logic       pop;
        logic [3:0] exp_rdy;
        logic       exp_pop;
        int         exp_occ;
    } step_t;

    typedef struct {
        int            due;
        logic [EW-1:0] d;
    } resp_t;

    logic user_clk = 1'b0;
    logic rst_n    = 1'b0;
    int   cyc      = 0;
    int   n_cmp    = 0;
    int   n_fail   = 0;

    always #5 user_clk = ~user_clk;

    bmw_op_sched_if #(.NPUSH(4), .EW(EW), .CNTW(17)) ifb ();
    bmw_op_sched_if #(.NPUSH(4), .EW(EW), .CNTW(3))  ifs ();

    assign ifs.push_valid   = ifb.push_valid;
    assign ifs.push_data    = ifb.push_data;
    assign ifs.pop_valid    = ifb.pop_valid;
    assign ifs.bmw_pop_data = ifb.bmw_pop_data;

    bmw_op_sched dut_b (
        .user_clk (user_clk),
        .rst_n    (rst_n),
        .bus      (ifb)
    );

    bmw_op_sched #(.CAPACITY(CAP)) dut_s (
        .user_clk (user_clk),
        .rst_n    (rst_n),
        .bus      (ifs)
    );

    function automatic logic [EW-1:0] pd(input int c);
        return {1'b1, 16'(c * 3), 16'(c)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge user_clk);
        cyc++;
        #2;
        ifb.bmw_pop_data = pd(cyc);
    endtask

    task automatic do_reset();
        ifb.push_valid = '0;
        ifb.pop_valid  = 1'b0;
        #1 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push1(input int port, input logic [EW-1:0] d);
        bit got;
        got = 0;
        ifb.push_data[port*EW +: EW] = d;
        ifb.push_valid = 4'(1 << port);
        for (int i = 0; i < 10 && !got; i++) begin
            #1;
            got = ifb.push_ready[port];
            tick();
        end
        ifb.push_valid = '0;
        chk("push_handshake", 64'(got), 64'd1);
    endtask

    task automatic pop1(output int h);
        bit got;
        got = 0;
        h = -1;
        ifb.pop_valid = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            #1;
            got = ifb.pop_ready;
            if (got) h = cyc;
            tick();
        end
        ifb.pop_valid = 1'b0;
        chk("pop_handshake", 64'(got), 64'd1);
    endtask

    initial begin
        step_t         tbl[14];
        int            kinds[$];
        resp_t         q[$];
        int            h, cnt;
        bit            got;
        int            m_occ, m_last, m_start, m_li, port;
        bit            m_ep, m_epop, gp, gpop, pe, ope, exp_rv;
        logic [EW-1:0] m_pdata;
        logic [3:0]    pv;

        tbl[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 1};
        tbl[1]  = '{4'b0101, 1'b0, 4'b0001, 1'b0, 2};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 1};
        tbl[3]  = '{4'b1111, 1'b1, 4'b0010, 1'b0, 2};
        tbl[4]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1};
        tbl[5]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1};
        tbl[6]  = '{4'b0011, 1'b0, 4'b0001, 1'b0, 2};
        tbl[7]  = '{4'b1001, 1'b0, 4'b1000, 1'b0, 3};
        tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2};
        tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1};
        tbl[10] = '{4'b1000, 1'b1, 4'b1000, 1'b0, 2};
        tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1};
        tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 0};
        tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 0};

        ifb.push_valid   = '0;
        ifb.push_data    = '0;
        ifb.pop_valid    = 1'b0;
        ifb.bmw_pop_data = '0;

        // Reset state and a single push on port 0
        do_reset();
        chk("rst_outs", 64'({ifb.push_ready, ifb.pop_ready, ifb.bmw_push, ifb.bmw_pop,
                             ifb.pop_resp_valid, ifb.full}), 64'd0);
        chk("rst_occ", 64'(ifb.occupancy), 64'd0);
        chk("rst_empty", 64'({ifb.empty, ifs.empty}), 64'b11);
        chk("rst_data", 64'({ifb.bmw_push_data, ifb.pop_resp_data}), 64'd0);
        ifb.push_data[EW-1:0] = EW'(5);
        ifb.push_valid = 4'b0001;
        #1;
        chk("t1_ready", 64'(ifb.push_ready), 64'd1);
        chk("t1_no_issue_yet", 64'(ifb.bmw_push), 64'd0);
        tick();
        ifb.push_valid = '0;
        #1;
        chk("t1_issue", 64'(ifb.bmw_push), 64'd1);
        chk("t1_issue_data", 64'(ifb.bmw_push_data), 64'd5);
        chk("t1_occ", 64'(ifb.occupancy), 64'd1);
        chk("t1_empty", 64'(ifb.empty), 64'd0);
        tick();
        #1;
        chk("t1_issue_1cyc", 64'(ifb.bmw_push), 64'd0);

        // Pop against an empty heap
        do_reset();
        ifb.pop_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("t2_empty_pop", 64'({ifb.pop_ready, ifb.bmw_pop}), 64'd0);
            tick();
        end
        ifb.pop_valid = 1'b0;

        // Arbitration table: each step at an open slot, then one idle gap cycle
        do_reset();
        foreach (tbl[i]) begin
            ifb.push_valid = tbl[i].pv;
            ifb.pop_valid  = tbl[i].pop;
            #1;
            chk("tbl_push_ready", 64'(ifb.push_ready), 64'(tbl[i].exp_rdy));
            chk("tbl_pop_ready", 64'(ifb.pop_ready), 64'(tbl[i].exp_pop));
            tick();
            ifb.push_valid = '0;
            ifb.pop_valid  = 1'b0;
            #1;
            chk("tbl_occ", 64'(ifb.occupancy), 64'(tbl[i].exp_occ));
            tick();
        end

        // All ports valid: grants 0,1,2,3,... two cycles apart
        do_reset();
        for (int k = 0; k < 4; k++) ifb.push_data[k*EW +: EW] = EW'(k + 1);
        ifb.push_valid = 4'hF;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("t3_grant", 64'(ifb.push_ready), (i % 2 == 0) ? 64'(1 << ((i / 2) % 4)) : 64'd0);
            chk("t3_issue", 64'(ifb.bmw_push), 64'(i % 2));
            if (i % 2 == 1) chk("t3_data", 64'(ifb.bmw_push_data), 64'(((i / 2) % 4) + 1));
            tick();
        end
        ifb.push_valid = '0;

        // Push/pop alternation from occupancy 3 after a pop
        do_reset();
        for (int i = 0; i < 4; i++) push1(0, EW'(i + 20));
        pop1(h);
        ifb.push_valid = 4'hF;
        ifb.pop_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (ifb.push_ready != 0) kinds.push_back(1);
            if (ifb.pop_ready) kinds.push_back(2);
            chk("t4_occ_range", 64'(ifb.occupancy >= 3 && ifb.occupancy <= 4), 64'd1);
            tick();
        end
        ifb.push_valid = '0;
        ifb.pop_valid  = 1'b0;
        chk("t4_grants", 64'(kinds.size()), 64'd8);
        foreach (kinds[j]) chk("t4_order", 64'(kinds[j]), (j % 2 == 0) ? 64'd1 : 64'd2);

        // CAPACITY=4 instance: fill, stall, one pop, one more push
        do_reset();
        cnt = 0;
        ifb.push_valid = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (ifs.push_ready[0]) cnt++;
            chk("t5_occ_max", 64'(ifs.occupancy <= CAP), 64'd1);
            tick();
        end
        #1;
        chk("t5_pushes", 64'(cnt), 64'd4);
        chk("t5_full", 64'(ifs.full), 64'd1);
        chk("t5_ready_when_full", 64'(ifs.push_ready), 64'd0);
        ifb.pop_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            #1;
            got = ifs.pop_ready;
            tick();
        end
        ifb.pop_valid = 1'b0;
        chk("t5_pop_hs", 64'(got), 64'd1);
        #1;
        chk("t5_occ_after_pop", 64'({ifs.occupancy, ifs.full}), 64'({3'd3, 1'b0}));
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            #1;
            got = ifs.push_ready[0];
            tick();
        end
        ifb.push_valid = '0;
        chk("t5_push_after_pop", 64'(got), 64'd1);
        #1;
        chk("t5_refull", 64'({ifs.occupancy, ifs.full}), 64'({3'd4, 1'b1}));
        tick();

        // Pop response latency and data, then reset with a pop in flight
        do_reset();
        push1(0, entry_t'{meta: '0, prio: 16'd9});
        push1(0, entry_t'{meta: '0, prio: 16'd2});
        push1(0, entry_t'{meta: '0, prio: 16'd7});
        pop1(h);
        #1;
        chk("t6_bmw_pop", 64'(ifb.bmw_pop), 64'd1);
        chk("t6_resp_h1", 64'(ifb.pop_resp_valid), 64'd0);
        tick();
        #1;
        chk("t6_resp_h2", 64'(ifb.pop_resp_valid), 64'd0);
        tick();
        #1;
        chk("t6_resp_h3", 64'(ifb.pop_resp_valid), 64'd1);
        chk("t6_resp_data", 64'(ifb.pop_resp_data), 64'(pd(h + 2)));
        tick();
        #1;
        chk("t6_resp_h4", 64'(ifb.pop_resp_valid), 64'd0);
        pop1(h);
        #1;
        chk("t6_inflight", 64'(ifb.bmw_pop), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_occ", 64'(ifb.occupancy), 64'd0);
        chk("t6_rst_outs", 64'({ifb.pop_resp_valid, ifb.bmw_pop}), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t6_dropped", 64'(ifb.pop_resp_valid), 64'd0);
            tick();
        end

        // Randomized run on the CAPACITY=4 instance against the reference model
        for (int n = 0; n < 3000; n++) begin
            if (n == 0 || n == 1500) begin
                do_reset();
                m_occ = 0; m_last = 0; m_start = 0; m_li = -100;
                m_ep = 0; m_epop = 0; m_pdata = '0;
                q.delete();
            end
            pv = 4'($urandom) & 4'($urandom);
            ifb.push_valid = pv;
            ifb.pop_valid  = 1'($urandom);
            for (int k = 0; k < 4; k++) ifb.push_data[k*EW +: EW] = EW'({$urandom, $urandom});
            #1;
            chk("r_bmw_push", 64'(ifs.bmw_push), 64'(m_ep));
            chk("r_bmw_pop", 64'(ifs.bmw_pop), 64'(m_epop));
            if (m_ep) chk("r_push_data", 64'(ifs.bmw_push_data), 64'(m_pdata));
            chk("r_occ", 64'(ifs.occupancy), 64'(m_occ));
            chk("r_flags", 64'({ifs.empty, ifs.full}), 64'({m_occ == 0, m_occ == CAP}));
            exp_rv = q.size() > 0 && q[0].due == cyc;
            chk("r_resp_valid", 64'(ifs.pop_resp_valid), 64'(exp_rv));
            if (exp_rv) begin
                chk("r_resp_data", 64'(ifs.pop_resp_data), 64'(q[0].d));
                void'(q.pop_front());
            end
            pe   = pv != 0 && m_occ < CAP;
            ope  = ifb.pop_valid && m_occ > 0;
            gp   = (cyc - m_li) >= GAP && pe && !(ope && m_last == 1);
            gpop = (cyc - m_li) >= GAP && ope && !gp;
            port = -1;
            for (int j = 0; j < 4; j++)
                if (port < 0 && pv[(m_start + j) % 4]) port = (m_start + j) % 4;
            chk("r_push_ready", 64'(ifs.push_ready), gp ? 64'(1 << port) : 64'd0);
            chk("r_pop_ready", 64'(ifs.pop_ready), 64'(gpop));
            m_ep = gp;
            m_epop = gpop;
            if (gp) begin
                m_pdata = ifb.push_data[port*EW +: EW];
                m_occ++;
                m_start = (port + 1) % 4;
                m_last = 1;
                m_li = cyc;
            end
            if (gpop) begin
                q.push_back('{cyc + 3, pd(cyc + 2)});
                m_occ--;
                m_last = 2;
                m_li = cyc;
            end
            tick();
        end
        ifb.push_valid = '0;
        ifb.pop_valid  = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
